// File: rtl/conv_encoder_sys.sv
// ---------------------------------------------------------------------------
// conv_encoder_sys
//
// Rate-1/2 feedforward convolutional encoder, constraint length K = 3..7
// selected per frame. Each frame is frame_len data bits followed by K-1 zero
// tail bits, so the decoder trellis always ends in state 0.
//
// Ports:
//   clk                      single clock, posedge
//   rst                      synchronous active-high reset
//   choose_constraint_length K, sampled on an accepted start (3..7 legal)
//   frame_len                data bits per frame, sampled on accepted start
//   start                    frame request, honoured only in IDLE
//   in_bit / in_valid        input data bit and its valid
//   in_ready                 encoder takes in_bit this cycle
//   encoded_bits             symbol: [1] = parity of g0, [0] = parity of g1
//   out_valid / out_ready    output symbol handshake
//   busy                     high outside IDLE
//   done                     pulse on the final tail symbol handshake
//   cfg_err                  pulse the cycle after a rejected start
// ---------------------------------------------------------------------------
module conv_encoder_sys #(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       choose_constraint_length,
   input  logic [LEN_W-1:0] frame_len,
   input  logic             start,
   input  logic             in_bit,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [1:0]       encoded_bits,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             done,
   output logic             cfg_err
);

   typedef enum logic [1:0] {IDLE, DATA, TAIL, DRAIN} state_t;

   state_t           state;
   state_t           state_next;

   logic [2:0]       k_reg;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] bit_cnt;
   logic [LEN_W-1:0] bit_cnt_inc;
   logic [2:0]       tail_cnt;
   logic [5:0]       hist;       // hist[0] is u[1], hist[5] is u[6]

   logic             start_ok;
   logic             slot_free;
   logic             out_fire;
   logic             load_data;
   logic             load_tail;
   logic             enc_bit;
   logic [1:0]       sym;

   // Parity of both generators over u[0..K-1]; u[0] is the bit being encoded.
   function automatic logic [1:0] encode(input logic [2:0] k, input logic [6:0] u);
      logic [6:0] g0;
      logic [6:0] g1;
      logic [6:0] mask;
      case (k)
         3'd3:    begin g0 = 7'o007; g1 = 7'o005; end
         3'd4:    begin g0 = 7'o017; g1 = 7'o013; end
         3'd5:    begin g0 = 7'o035; g1 = 7'o023; end
         3'd6:    begin g0 = 7'o075; g1 = 7'o053; end
         default: begin g0 = 7'o171; g1 = 7'o133; end
      endcase
      // Drop history taps beyond the active constraint length.
      mask = 7'h7f >> (3'd7 - k);
      return {^(u & g0 & mask), ^(u & g1 & mask)};
   endfunction

   // A 3-bit K cannot exceed 7, so only the lower bound needs checking.
   assign start_ok    = (choose_constraint_length >= 3'd3) && (frame_len != '0);
   assign slot_free   = !out_valid || out_ready;
   assign out_fire    = out_valid && out_ready;
   assign load_data   = (state == DATA) && in_valid && slot_free;
   assign load_tail   = (state == TAIL) && slot_free;
   assign bit_cnt_inc = bit_cnt + 1'b1;
   assign enc_bit     = (state == DATA) ? in_bit : 1'b0;  // tail bits are zero
   assign sym         = encode(k_reg, {hist, enc_bit});

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // NOTE: every output of this block gets a default first, so no path leaves
   // a signal unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      busy       = (state != IDLE);
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (start && start_ok) state_next = DATA;
         end
         DATA: begin
            in_ready = slot_free;
            if (load_data && (bit_cnt_inc == len_reg)) state_next = TAIL;
         end
         TAIL: begin
            // The symbol that takes the tail counter to zero is the last one.
            if (load_tail && (tail_cnt == 3'd1)) state_next = DRAIN;
         end
         DRAIN: begin
            if (out_fire) begin
               done       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         k_reg        <= 3'd0;
         len_reg      <= '0;
         bit_cnt      <= '0;
         tail_cnt     <= 3'd0;
         hist         <= 6'd0;
         encoded_bits <= 2'd0;
         out_valid    <= 1'b0;
         cfg_err      <= 1'b0;
      end else begin
         cfg_err <= (state == IDLE) && start && !start_ok;

         case (state)
            IDLE: begin
               if (start && start_ok) begin
                  k_reg   <= choose_constraint_length;
                  len_reg <= frame_len;
                  bit_cnt <= '0;
                  hist    <= 6'd0;
               end
            end
            DATA: begin
               if (load_data) begin
                  bit_cnt <= bit_cnt_inc;
                  if (bit_cnt_inc == len_reg) tail_cnt <= k_reg - 3'd1;
               end
            end
            TAIL: begin
               if (load_tail) tail_cnt <= tail_cnt - 3'd1;
            end
            default: ;
         endcase

         // A new symbol may replace one being accepted in the same cycle,
         // which keeps throughput at one symbol per cycle.
         if (load_data || load_tail) begin
            encoded_bits <= sym;
            out_valid    <= 1'b1;
            hist         <= {hist[4:0], enc_bit};
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_conv_encoder_sys.sv
module tb_conv_encoder_sys;

   localparam int LEN_W = 16;

   logic             clk;
   logic             rst;
   logic [2:0]       choose_constraint_length;
   logic [LEN_W-1:0] frame_len;
   logic             start;
   logic             in_bit;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       encoded_bits;
   logic             out_valid;
   logic             out_ready;
   logic             busy;
   logic             done;
   logic             cfg_err;

   int n_cmp = 0;
   int n_err = 0;

   bit         frame_bits[$];
   logic [1:0] got_q[$];

   conv_encoder_sys #(.LEN_W(LEN_W)) dut (
      .clk                      (clk),
      .rst                      (rst),
      .choose_constraint_length (choose_constraint_length),
      .frame_len                (frame_len),
      .start                    (start),
      .in_bit                   (in_bit),
      .in_valid                 (in_valid),
      .in_ready                 (in_ready),
      .encoded_bits             (encoded_bits),
      .out_valid                (out_valid),
      .out_ready                (out_ready),
      .busy                     (busy),
      .done                     (done),
      .cfg_err                  (cfg_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: symbol n of a frame is the generator parity over the input
   // sequence (data bits then zeros) looking back j = 0..K-1 positions.
   function automatic logic [1:0] ref_sym(input int k, input int len, input int n);
      int   g0;
      int   g1;
      logic p0;
      logic p1;
      logic u;
      case (k)
         3:       begin g0 = 'o7;   g1 = 'o5;   end
         4:       begin g0 = 'o17;  g1 = 'o13;  end
         5:       begin g0 = 'o35;  g1 = 'o23;  end
         6:       begin g0 = 'o75;  g1 = 'o53;  end
         default: begin g0 = 'o171; g1 = 'o133; end
      endcase
      p0 = 1'b0;
      p1 = 1'b0;
      for (int j = 0; j < k; j++) begin
         u  = (n - j >= 0 && n - j < len) ? frame_bits[n - j] : 1'b0;
         p0 = p0 ^ (g0[j] & u);
         p1 = p1 ^ (g1[j] & u);
      end
      return {p0, p1};
   endfunction

   task automatic load_random_bits(input int len);
      frame_bits.delete();
      for (int i = 0; i < len; i++) frame_bits.push_back(1'($urandom_range(0, 1)));
   endtask

   // Starts a frame and streams it through; entered and left in the low clock
   // phase. Collected symbols are left in got_q.
   task automatic run_frame(input int k, input int len, input int ready_pct,
                            input int valid_pct, input bit noise, input string name);
      logic [1:0] exp_q[$];
      int         nsym;
      int         idx;
      int         cycle;
      int         first_acc;
      int         first_fire;
      int         last_fire;
      bit         prev_hold;
      logic [1:0] prev_sym;
      bit         finished;
      bit         fire;
      bit         acc;
      logic [1:0] got;

      nsym = len + k - 1;
      for (int n = 0; n < nsym; n++) exp_q.push_back(ref_sym(k, len, n));
      got_q.delete();

      choose_constraint_length = k[2:0];
      frame_len                = len[LEN_W-1:0];
      start                    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      #1;
      n_cmp++;
      if (busy !== 1'b1 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL %s start: busy=%b in_ready=%b, required 1/1", name, busy, in_ready);
      end

      idx        = 0;
      cycle      = 0;
      first_acc  = -1;
      first_fire = -1;
      last_fire  = -1;
      prev_hold  = 1'b0;
      prev_sym   = 2'd0;
      finished   = 1'b0;
      while (!finished && cycle < 4000) begin
         out_ready = ($urandom_range(0, 99) < ready_pct);
         in_valid  = (idx < len) && ($urandom_range(0, 99) < valid_pct);
         in_bit    = (idx < len) ? frame_bits[idx] : 1'($urandom_range(0, 1));
         if (noise) begin
            start                    = 1'($urandom_range(0, 1));
            choose_constraint_length = 3'($urandom_range(0, 7));
            frame_len                = LEN_W'($urandom);
         end
         #1;
         fire = out_valid && out_ready;
         acc  = in_valid && in_ready;

         if (prev_hold) begin
            n_cmp++;
            if (out_valid !== 1'b1 || encoded_bits !== prev_sym) begin
               n_err++;
               $display("FAIL %s hold c%0d: valid=%b sym=%0d, required 1/%0d",
                        name, cycle, out_valid, encoded_bits, prev_sym);
            end
         end
         if (idx >= len) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin
               n_err++;
               $display("FAIL %s in_ready_tail c%0d: got %b, required 0", name, cycle, in_ready);
            end
         end
         n_cmp++;
         if (busy !== 1'b1 || cfg_err !== 1'b0) begin
            n_err++;
            $display("FAIL %s busy/cfg_err c%0d: got %b/%b, required 1/0", name, cycle, busy, cfg_err);
         end

         if (fire) begin
            if (first_fire < 0) first_fire = cycle;
            last_fire = cycle;
            got_q.push_back(encoded_bits);
         end
         n_cmp++;
         if (done !== (fire && got_q.size() == nsym)) begin
            n_err++;
            $display("FAIL %s done c%0d: got %b, required %b",
                     name, cycle, done, fire && got_q.size() == nsym);
         end
         if (fire && got_q.size() >= nsym) finished = 1'b1;

         if (acc) begin
            if (first_acc < 0) first_acc = cycle;
            idx++;
         end
         prev_hold = out_valid && !out_ready;
         prev_sym  = encoded_bits;
         @(negedge clk);
         cycle++;
      end

      start     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_cmp++;
      if (!finished) begin
         n_err++;
         $display("FAIL %s timeout: got %0d symbols, required %0d", name, got_q.size(), nsym);
      end
      #1;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL %s after_done: busy=%b done=%b valid=%b, required 0/0/0",
                  name, busy, done, out_valid);
      end

      n_cmp++;
      if (got_q.size() != nsym) begin
         n_err++;
         $display("FAIL %s count: got %0d symbols, required %0d", name, got_q.size(), nsym);
      end
      for (int i = 0; i < nsym; i++) begin
         got = (i < got_q.size()) ? got_q[i] : 2'bxx;
         n_cmp++;
         if (got !== exp_q[i]) begin
            n_err++;
            $display("FAIL %s sym[%0d]: got %0d, required %0d", name, i, got, exp_q[i]);
         end
      end

      if (ready_pct >= 100 && valid_pct >= 100) begin
         n_cmp++;
         if (first_fire != first_acc + 1 || last_fire - first_fire != nsym - 1) begin
            n_err++;
            $display("FAIL %s rate: first_acc=%0d first_sym=%0d last_sym=%0d, required +1 and span %0d",
                     name, first_acc, first_fire, last_fire, nsym - 1);
         end
      end
   endtask

   task automatic check_k3_1011(input string name);
      logic [1:0] lit [6];
      logic [1:0] got;
      lit = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3};
      for (int i = 0; i < 6; i++) begin
         got = (i < got_q.size()) ? got_q[i] : 2'bxx;
         n_cmp++;
         if (got !== lit[i]) begin
            n_err++;
            $display("FAIL %s vec[%0d]: got %0d, required %0d", name, i, got, lit[i]);
         end
      end
   endtask

   task automatic test_reset();
      rst                      = 1'b1;
      start                    = 1'b0;
      in_bit                   = 1'b0;
      in_valid                 = 1'b0;
      out_ready                = 1'b0;
      choose_constraint_length = 3'd0;
      frame_len                = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if ({encoded_bits, out_valid, in_ready, busy, done, cfg_err} !== 7'd0) begin
         n_err++;
         $display("FAIL reset: sym=%0d valid=%b in_ready=%b busy=%b done=%b cfg_err=%b, required all 0",
                  encoded_bits, out_valid, in_ready, busy, done, cfg_err);
      end
      rst = 1'b0;
   endtask

   task automatic test_k3_directed();
      frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
      run_frame(3, 4, 100, 100, 1'b0, "k3");
      check_k3_1011("k3");
   endtask

   task automatic test_k7_impulse();
      logic [1:0] lit [7];
      logic [1:0] got;
      lit = '{2'd3, 2'd1, 2'd0, 2'd3, 2'd3, 2'd2, 2'd3};
      frame_bits = '{1'b1};
      run_frame(7, 1, 100, 100, 1'b0, "k7_impulse");
      for (int i = 0; i < 7; i++) begin
         got = (i < got_q.size()) ? got_q[i] : 2'bxx;
         n_cmp++;
         if (got !== lit[i]) begin
            n_err++;
            $display("FAIL k7_impulse vec[%0d]: got %0d, required %0d", i, got, lit[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
      run_frame(3, 4, 50, 60, 1'b1, "k3_bp");
      check_k3_1011("k3_bp");
   endtask

   task automatic test_cfg_err();
      int pulses = 0;
      for (int t = 0; t < 2; t++) begin
         choose_constraint_length = (t == 0) ? 3'd2 : 3'd4;
         frame_len                = (t == 0) ? LEN_W'(5) : '0;
         start                    = 1'b1;
         @(posedge clk);
         @(negedge clk);
         start = 1'b0;
         #1;
         if (cfg_err === 1'b1) pulses++;
         n_cmp++;
         if (cfg_err !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_err%0d: cfg_err=%b busy=%b valid=%b, required 1/0/0",
                     t, cfg_err, busy, out_valid);
         end
         @(negedge clk);
         #1;
         n_cmp++;
         if (cfg_err !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_err%0d_after: cfg_err=%b busy=%b valid=%b, required 0/0/0",
                     t, cfg_err, busy, out_valid);
         end
      end
      n_cmp++;
      if (pulses != 2) begin
         n_err++;
         $display("FAIL cfg_err_pulses: got %0d, required 2", pulses);
      end
   endtask

   task automatic test_reset_midframe();
      int acc_n = 0;
      int cyc   = 0;
      choose_constraint_length = 3'd5;
      frame_len                = LEN_W'(10);
      start                    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      while (acc_n < 6 && cyc < 200) begin
         out_ready = 1'b1;
         in_valid  = 1'b1;
         in_bit    = 1'($urandom_range(0, 1));
         #1;
         if (in_valid && in_ready) acc_n++;
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (acc_n != 6) begin
         n_err++;
         $display("FAIL rst_mid accept: got %0d bits, required 6", acc_n);
      end
      in_valid = 1'b0;
      rst      = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++;
      if ({encoded_bits, out_valid, in_ready, busy, done, cfg_err} !== 7'd0) begin
         n_err++;
         $display("FAIL rst_mid: sym=%0d valid=%b in_ready=%b busy=%b done=%b cfg_err=%b, required all 0",
                  encoded_bits, out_valid, in_ready, busy, done, cfg_err);
      end
      frame_bits = '{1'b1, 1'b0, 1'b1, 1'b1};
      run_frame(3, 4, 100, 100, 1'b0, "k3_after_rst");
      check_k3_1011("k3_after_rst");
   endtask

   task automatic test_back_to_back();
      load_random_bits(5);
      run_frame(3, 5, 100, 100, 1'b0, "b2b_k3");
      load_random_bits(6);
      run_frame(4, 6, 100, 100, 1'b0, "b2b_k4");
      n_cmp++;
      if (got_q.size() - 6 != 3) begin
         n_err++;
         $display("FAIL b2b_tail: got %0d tail symbols, required 3", got_q.size() - 6);
      end
   endtask

   task automatic test_random();
      int k;
      int len;
      for (int f = 0; f < 10; f++) begin
         k   = $urandom_range(3, 7);
         len = $urandom_range(1, 24);
         load_random_bits(len);
         run_frame(k, len, $urandom_range(30, 100), $urandom_range(30, 100), 1'b1,
                   $sformatf("rand%0d_k%0d", f, k));
      end
   endtask

   initial begin
      test_reset();
      test_k3_directed();
      test_k7_impulse();
      test_backpressure();
      test_cfg_err();
      test_reset_midframe();
      test_back_to_back();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
